fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
UART transmitter that drains the team's 8-bit single-clock FIFO from its read side. It watches `empty` and the show-ahead `data_out`, and issues one-cycle `rd_en` pops. Each popped byte is serialized as an asynchronous serial frame on `tx`. It sits directly behind the FIFO, so a producer can write bytes and let them stream off-chip without further control.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_en  input  1  permits new frames to start; never aborts a frame already in progress.
- fifo_empty  input  1  FIFO `empty` flag.
- fifo_data  input  8  FIFO show-ahead `data_out`; valid whenever fifo_empty = 0.
- fifo_rd_en  output  1  pop strobe to the FIFO; high for exactly one cycle per byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset: clk with asynchronous active-low rst_n. Reset forces the following immediately, regardless of clk:
  - state = IDLE
  - tx = 1, busy = 0, frame_done = 0
  - baud counter = 0, bit index = 0, shift register = 0
  - fifo_rd_en = 0
- Reset mid-frame: the frame is truncated with tx held high. No pop occurs during reset.
- States: IDLE, START, DATA, PAR, STOP.
- fifo_rd_en is a combinational decode, true only when tx_en = 1 and fifo_empty = 0 and either:
  - state = IDLE, or
  - state = STOP on the final cycle of the final stop bit.
- Pop edge: on the rising edge where fifo_rd_en = 1:
  - shift register <= fifo_data
  - state <= START, tx <= 0, busy <= 1
  - baud counter <= CLKS_PER_BIT-1
- Bit timing: every bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts down, and the bit advances on the cycle where the counter = 0.
- Bit order and transitions:
  - START → DATA: tx = bit0.
  - DATA shifts out LSB first, 8 bits.
  - After bit7: go to PAR if PARITY != 0, else go to STOP.
- Parity bit value:
  - even mode: XOR of the 8 data bits.
  - odd mode: the inverse of that XOR.
  - Computed from the byte captured at the pop edge, not from fifo_data.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
- End of the last stop bit:
  - frame_done pulses 1 cycle.
  - If fifo_rd_en = 1: go straight to START with a zero-cycle gap (back-to-back frames).
  - Otherwise: go to IDLE, busy = 0.
- Frame length: CLKS_PER_BIT × (10 + (PARITY != 0) + (STOP_BITS − 1)) cycles.
- Latency: the first start-bit cycle is the cycle immediately after the pop edge. In IDLE with a non-empty FIFO and tx_en = 1, the pop happens on the next edge.
- tx_en deasserted mid-frame: the current frame completes normally, then the block goes to IDLE with no further pop.
- tx is driven from a flop, so there are no glitches.
- fifo_data is ignored outside the pop cycle. FIFO changes during a frame do not affect the byte being sent.
- Never pops when fifo_empty = 1, so the FIFO's underflow guard is never exercised.
- Widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit index is 3 bits, wrapping 7 → 0 at the DATA exit.

Decomposition:
- Package fifo_uart_pkg:
  - state enum (IDLE/START/DATA/PAR/STOP).
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - DATA_W = 8.
- One natural sub-module: uart_baud_counter. It takes a load, reloads to CLKS_PER_BIT-1 and outputs a bit_end strike. fifo_uart_tx instantiates it once.

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0: push 0xA5, tx_en=1.
   - Required: one fifo_rd_en pulse.
   - tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles, 40 cycles total.
   - frame_done pulses once at the end; busy falls the next cycle.
2. PARITY=1, then PARITY=2: send 0xA5 (four ones) and 0x07 (three ones).
   - Even mode: parity bit 0 for 0xA5, 1 for 0x07.
   - Odd mode: the inverse of each.
   - Frame is 44 cycles at CLKS_PER_BIT=4.
3. Back-to-back: preload 0x01, 0x02, 0x03.
   - Three pops, each coincident with the final stop cycle of the previous frame.
   - No idle cycle between frames; 120 cycles total; FIFO empty afterwards.
4. Assert rst_n=0 at cycle 15 of a 0xFF frame.
   - tx = 1 and busy = 0 immediately, without waiting for a clock edge.
   - After release with an empty FIFO: no pop and tx stays high.
5. Drop tx_en mid-frame with 2 bytes queued.
   - The current frame finishes with frame_done.
   - No further pop while tx_en = 0.
   - Re-asserting tx_en pops on the next edge.
6. STOP_BITS=2, CLKS_PER_BIT=2, fifo_empty held high.
   - No pops.
   - Then one byte 0x00: tx low for 18 cycles (start + 8 data bits) then high for 4 cycles.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Frame states, parity mode encodings and the parity helper live here.
package fifo_uart_pkg;

   localparam int DATA_W   = 8;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   // Even parity is the XOR of the byte; odd parity is its inverse.
   function automatic logic parity_bit(input logic [DATA_W-1:0] d, input int mode);
      return (^d) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Down-counting bit timer: load restarts a bit, bit_end marks its final cycle.
// Holds at zero while the transmitter is idle.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic bit_end
);

   localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (!run) begin
         count <= '0;
      end else if (count == '0) begin
         count <= RELOAD;
      end else begin
         count <= count - CW'(1);
      end
   end

   assign bit_end = (count == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO: pops one byte per frame and
// serializes start, 8 data bits (LSB first), optional parity and stop bits.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam logic LAST_STOP = (STOP_BITS == 2);

   state_t            state, state_nx;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic [2:0]        bit_idx, bit_idx_nx;
   logic              stop_idx, stop_idx_nx;
   logic              par, par_nx;
   logic              tx_nx;
   logic              busy_nx;
   logic              bit_end;
   logic              frame_end;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (fifo_rd_en),
      .run    (state != IDLE),
      .bit_end(bit_end)
   );

   assign frame_end  = (state == STOP) && bit_end && (stop_idx == LAST_STOP);
   assign frame_done = frame_end;
   // Gating with rst_n keeps the FIFO untouched while reset is held.
   assign fifo_rd_en = rst_n && tx_en && !fifo_empty && ((state == IDLE) || frame_end);

   always_comb begin
      state_nx    = state;
      shreg_nx    = shreg;
      bit_idx_nx  = bit_idx;
      stop_idx_nx = stop_idx;
      par_nx      = par;
      tx_nx       = tx;
      busy_nx     = busy;

      if (fifo_rd_en) begin
         state_nx    = START;
         shreg_nx    = fifo_data;
         par_nx      = parity_bit(fifo_data, PARITY);
         bit_idx_nx  = '0;
         stop_idx_nx = 1'b0;
         tx_nx       = 1'b0;
         busy_nx     = 1'b1;
      end else if (bit_end) begin
         case (state)
            START: begin
               state_nx = DATA;
               tx_nx    = shreg[0];
               shreg_nx = shreg >> 1;
            end
            DATA: begin
               bit_idx_nx = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  stop_idx_nx = 1'b0;
                  if (PARITY != PAR_NONE) begin
                     state_nx = PAR;
                     tx_nx    = par;
                  end else begin
                     state_nx = STOP;
                     tx_nx    = 1'b1;
                  end
               end else begin
                  tx_nx    = shreg[0];
                  shreg_nx = shreg >> 1;
               end
            end
            PAR: begin
               state_nx    = STOP;
               tx_nx       = 1'b1;
               stop_idx_nx = 1'b0;
            end
            STOP: begin
               if (stop_idx == LAST_STOP) begin
                  state_nx = IDLE;
                  busy_nx  = 1'b0;
                  tx_nx    = 1'b1;
               end else begin
                  stop_idx_nx = 1'b1;
               end
            end
            default: begin
               state_nx = state;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         par      <= 1'b0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         shreg    <= shreg_nx;
         bit_idx  <= bit_idx_nx;
         stop_idx <= stop_idx_nx;
         par      <= par_nx;
         tx       <= tx_nx;
         busy     <= busy_nx;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four instances with different framing options, each
// fed by a small FIFO model, checked against frames built from the bit rules.
module tb_fifo_uart_tx;

   localparam int CPB_T[4] = '{4, 4, 4, 2};
   localparam int PAR_T[4] = '{0, 1, 2, 0};
   localparam int SB_T[4]  = '{1, 1, 1, 2};

   logic       clk;
   logic       rst_n;
   logic [3:0] tx_en_v;
   logic [3:0] empty_v;
   logic [3:0] rd_en_v;
   logic [3:0] tx_v;
   logic [3:0] busy_v;
   logic [3:0] done_v;
   logic [7:0] data_v [4];
   logic [7:0] mem [4][16];
   int         wr_ptr [4];
   int         rd_ptr [4];
   int         checks;
   int         errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      assign empty_v[g] = (wr_ptr[g] == rd_ptr[g]);
      assign data_v[g]  = mem[g][rd_ptr[g] % 16];

      fifo_uart_tx #(
         .CLKS_PER_BIT(CPB_T[g]),
         .PARITY      (PAR_T[g]),
         .STOP_BITS   (SB_T[g])
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .tx_en     (tx_en_v[g]),
         .fifo_empty(empty_v[g]),
         .fifo_data (data_v[g]),
         .fifo_rd_en(rd_en_v[g]),
         .tx        (tx_v[g]),
         .busy      (busy_v[g]),
         .frame_done(done_v[g])
      );
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rd_en_v[i]) rd_ptr[i] <= rd_ptr[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input logic [7:0] b);
      mem[d][wr_ptr[d] % 16] = b;
      wr_ptr[d]++;
   endtask

   // Line level for a given bit slot of a frame: start, data LSB first, parity, stops.
   function automatic logic exp_bit(input logic [7:0] b, input int par, input int slot);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      if (par != 0 && slot == 9) return (^b) ^ (par == 2);
      return 1'b1;
   endfunction

   task automatic wait_pop(input int d);
      bit found = 1'b0;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (rd_en_v[d]) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk($sformatf("u%0d_pop_seen", d), {31'd0, found}, 32'd1);
   endtask

   task automatic check_frame(input int d, input int cpb, input int par, input int sb,
                              input logic [7:0] b, input bit pop_end, input int drop_at);
      int slots = 10 + ((par != 0) ? 1 : 0) + (sb - 1);
      int flen  = slots * cpb;
      for (int c = 0; c < flen; c++) begin
         @(negedge clk);
         if (c == drop_at) tx_en_v[d] = 1'b0;
         chk($sformatf("u%0d_b%0h_tx_c%0d", d, b, c), {31'd0, tx_v[d]},
             {31'd0, exp_bit(b, par, c / cpb)});
         chk($sformatf("u%0d_b%0h_busy_c%0d", d, b, c), {31'd0, busy_v[d]}, 32'd1);
         chk($sformatf("u%0d_b%0h_done_c%0d", d, b, c), {31'd0, done_v[d]},
             (c == flen - 1) ? 32'd1 : 32'd0);
         chk($sformatf("u%0d_b%0h_rd_c%0d", d, b, c), {31'd0, rd_en_v[d]},
             (c == flen - 1 && pop_end) ? 32'd1 : 32'd0);
      end
      if (!pop_end) begin
         @(negedge clk);
         chk($sformatf("u%0d_b%0h_busy_after", d, b), {31'd0, busy_v[d]}, 32'd0);
         chk($sformatf("u%0d_b%0h_tx_after", d, b), {31'd0, tx_v[d]}, 32'd1);
      end
   endtask

   task automatic idle_checks(input int d, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s_rd_%0d", tag, i), {31'd0, rd_en_v[d]}, 32'd0);
         chk($sformatf("%s_tx_%0d", tag, i), {31'd0, tx_v[d]}, 32'd1);
         chk($sformatf("%s_busy_%0d", tag, i), {31'd0, busy_v[d]}, 32'd0);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      tx_en_v = 4'hF;
      for (int i = 0; i < 4; i++) begin
         wr_ptr[i] = 0;
         rd_ptr[i] = 0;
      end

      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("rst_tx_u%0d", d), {31'd0, tx_v[d]}, 32'd1);
         chk($sformatf("rst_busy_u%0d", d), {31'd0, busy_v[d]}, 32'd0);
         chk($sformatf("rst_done_u%0d", d), {31'd0, done_v[d]}, 32'd0);
         chk($sformatf("rst_rd_u%0d", d), {31'd0, rd_en_v[d]}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Empty FIFO on the two-stop-bit instance: nothing may be popped.
      idle_checks(3, 10, "u3_empty");

      // Single 0xA5 frame, no parity.
      push(0, 8'hA5);
      wait_pop(0);
      check_frame(0, 4, 0, 1, 8'hA5, 1'b0, -1);

      // Even and odd parity, 0xA5 then 0x07 back to back.
      push(1, 8'hA5);
      push(1, 8'h07);
      wait_pop(1);
      check_frame(1, 4, 1, 1, 8'hA5, 1'b1, -1);
      check_frame(1, 4, 1, 1, 8'h07, 1'b0, -1);
      push(2, 8'hA5);
      push(2, 8'h07);
      wait_pop(2);
      check_frame(2, 4, 2, 1, 8'hA5, 1'b1, -1);
      check_frame(2, 4, 2, 1, 8'h07, 1'b0, -1);

      // Three queued bytes stream with no gap.
      push(0, 8'h01);
      push(0, 8'h02);
      push(0, 8'h03);
      wait_pop(0);
      check_frame(0, 4, 0, 1, 8'h01, 1'b1, -1);
      check_frame(0, 4, 0, 1, 8'h02, 1'b1, -1);
      check_frame(0, 4, 0, 1, 8'h03, 1'b0, -1);
      chk("b2b_fifo_empty", {31'd0, empty_v[0]}, 32'd1);

      // A handful of random bytes through the parity instances.
      for (int k = 0; k < 3; k++) begin
         logic [7:0] rb;
         rb = 8'($urandom_range(0, 255));
         push(1, rb);
         wait_pop(1);
         check_frame(1, 4, 1, 1, rb, 1'b0, -1);
         rb = 8'($urandom_range(0, 255));
         push(2, rb);
         wait_pop(2);
         check_frame(2, 4, 2, 1, rb, 1'b0, -1);
      end

      // tx_en dropped mid-frame with a second byte waiting.
      push(0, 8'h3C);
      push(0, 8'hC3);
      wait_pop(0);
      check_frame(0, 4, 0, 1, 8'h3C, 1'b0, 10);
      idle_checks(0, 5, "u0_txen_off");
      chk("txen_off_not_empty", {31'd0, empty_v[0]}, 32'd0);
      tx_en_v[0] = 1'b1;
      #1;
      chk("txen_on_rd", {31'd0, rd_en_v[0]}, 32'd1);
      check_frame(0, 4, 0, 1, 8'hC3, 1'b0, -1);

      // Asynchronous reset in the middle of a 0xFF frame.
      push(0, 8'hFF);
      wait_pop(0);
      repeat (15) @(negedge clk);
      chk("midrst_busy_before", {31'd0, busy_v[0]}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_tx", {31'd0, tx_v[0]}, 32'd1);
      chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
      chk("midrst_rd", {31'd0, rd_en_v[0]}, 32'd0);
      chk("midrst_done", {31'd0, done_v[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_checks(0, 10, "u0_post_rst");
      chk("post_rst_empty", {31'd0, empty_v[0]}, 32'd1);

      // Two stop bits at two clocks per bit, byte 0x00.
      push(3, 8'h00);
      wait_pop(3);
      check_frame(3, 2, 0, 2, 8'h00, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
